// File: rtl/key_operand_entry_pkg.sv
// Shared types and constants for the keypad operand entry stage.
// Scan FSM encoding and row-pattern decode helpers.
package key_operand_entry_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } scan_state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] KEY_IDLE = 4'hF;

  // True when exactly one row line is pulled low.
  function automatic logic one_low(input logic [3:0] p);
    logic [3:0] n;
    n = ~p;
    return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] p);
    if (!p[0]) return 2'd0;
    else if (!p[1]) return 2'd1;
    else if (!p[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/key_scan_debounce.sv
// 4x4 keypad column scanner with press/release debounce.
// Emits one key_strobe per accepted key; multi-row presses are rejected.
module key_scan_debounce
  import key_operand_entry_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_r,
  output logic [3:0] key_c,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  scan_state_t   state_q, state_d;
  logic [3:0]    r1, rs;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    code_d;
  logic          strobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1         <= KEY_IDLE;
      rs         <= KEY_IDLE;
      state_q    <= SCAN;
      col_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      pat_q      <= KEY_IDLE;
      key_strobe <= 1'b0;
      key_code   <= '0;
    end else begin
      r1         <= key_r;
      rs         <= r1;
      state_q    <= state_d;
      col_q      <= col_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      key_strobe <= strobe_d;
      key_code   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    strobe_d = 1'b0;
    code_d   = key_code;
    unique case (state_q)
      SCAN: begin
        if (div_q == DW'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (rs != KEY_IDLE) begin
            pat_d   = rs;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != pat_q || rs == KEY_IDLE) begin
          state_d = SCAN;
          cnt_d   = '0;
          div_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = HOLD;
          if (one_low(pat_q)) begin
            strobe_d = 1'b1;
            code_d   = {row_of(pat_q), col_q};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // Column stays put until the keypad is released long enough.
        if (rs != KEY_IDLE) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          cnt_d   = '0;
          div_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign key_c = ~(4'b0001 << col_q);

endmodule

// File: rtl/key_operand_entry.sv
// Keypad operand entry: four hex digits become X/Y operands
// offered to the multiplier through a valid/ack handshake.
module key_operand_entry
  import key_operand_entry_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE_CYC = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  KEY_R,
  output logic [3:0]  KEY_C,
  input  logic        op_ack,
  output logic [7:0]  X,
  output logic [7:0]  Y,
  output logic        op_valid,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [2:0]  digit_cnt,
  output logic [15:0] entry_buf
);

  key_scan_debounce #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_scan (
    .clk        (clk),
    .rst        (clr),
    .key_r      (KEY_R),
    .key_c      (KEY_C),
    .key_strobe (key_strobe),
    .key_code   (key_code)
  );

  localparam logic [2:0] FULL = 3'(NUM_DIGITS);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      X         <= '0;
      Y         <= '0;
      op_valid  <= 1'b0;
      digit_cnt <= '0;
      entry_buf <= '0;
    end else if (op_valid) begin
      // Keys arriving now are dropped; only the ack matters.
      if (op_ack) begin
        op_valid  <= 1'b0;
        digit_cnt <= '0;
      end
    end else if (digit_cnt == FULL) begin
      X        <= entry_buf[15:8];
      Y        <= entry_buf[7:0];
      op_valid <= 1'b1;
    end else if (key_strobe) begin
      entry_buf <= {entry_buf[11:0], key_code};
      digit_cnt <= digit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_key_operand_entry.sv
// Directed bench for key_operand_entry with a behavioural keypad
// that pulls rows low when the matching column is driven.
module tb_key_operand_entry;

  logic        clk;
  logic        clr;
  logic [3:0]  KEY_R;
  logic [3:0]  KEY_C;
  logic        op_ack;
  logic [7:0]  X, Y;
  logic        op_valid;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [2:0]  digit_cnt;
  logic [15:0] entry_buf;

  logic       pressed;
  logic [3:0] prow;
  logic [1:0] pcol;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int nstb = 0;
  int last_stb = -1;

  key_operand_entry #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .KEY_R      (KEY_R),
    .KEY_C      (KEY_C),
    .op_ack     (op_ack),
    .X          (X),
    .Y          (Y),
    .op_valid   (op_valid),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .digit_cnt  (digit_cnt),
    .entry_buf  (entry_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    KEY_R = 4'hF;
    if (pressed && !KEY_C[pcol]) KEY_R = ~prow;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (key_strobe) begin
      nstb     <= nstb + 1;
      last_stb <= cyc;
    end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step(2);
    clr = 1'b0;
    step(1);
  endtask

  task automatic set_key(input logic [3:0] code);
    prow = 4'b0001 << code[3:2];
    pcol = code[1:0];
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    set_key(code);
    pressed = 1'b1;
    step(hold);
    pressed = 1'b0;
    step(30);
  endtask

  task automatic wait_col(input logic [3:0] kc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (KEY_C == kc) ok = 1'b1;
      else step(1);
    end
  endtask

  initial begin
    int s0;
    int t0;
    logic ok;
    pressed = 1'b0;
    prow = 4'h0;
    pcol = 2'd0;
    op_ack = 1'b0;
    clr = 1'b1;

    // Reset state
    do_reset();
    check("rst_keyc", KEY_C, 4'b1110);
    check("rst_x", X, 8'h00);
    check("rst_y", Y, 8'h00);
    check("rst_valid", op_valid, 1'b0);
    check("rst_strobe", key_strobe, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_cnt", digit_cnt, 3'd0);
    check("rst_buf", entry_buf, 16'h0000);

    // Single press: row1/col2 -> 6
    s0 = nstb;
    press(4'h6, 30);
    check("single_strobes", nstb - s0, 1);
    check("single_code", key_code, 4'h6);
    check("single_cnt", digit_cnt, 3'd1);
    check("single_buf", entry_buf, 16'h0006);

    // Full entry 1,2,0,3 then ack
    do_reset();
    press(4'h1, 40);
    press(4'h2, 40);
    press(4'h0, 40);
    press(4'h3, 40);
    check("full_valid", op_valid, 1'b1);
    check("full_x", X, 8'h12);
    check("full_y", Y, 8'h03);
    check("full_cnt", digit_cnt, 3'd4);
    check("full_buf", entry_buf, 16'h1203);
    op_ack = 1'b1;
    step(1);
    op_ack = 1'b0;
    step(1);
    check("ack_valid", op_valid, 1'b0);
    check("ack_cnt", digit_cnt, 3'd0);
    check("ack_x", X, 8'h12);
    check("ack_y", Y, 8'h03);
    check("ack_buf", entry_buf, 16'h1203);
    op_ack = 1'b1;
    step(1);
    op_ack = 1'b0;
    step(1);
    check("idle_ack_valid", op_valid, 1'b0);
    check("idle_ack_cnt", digit_cnt, 3'd0);

    // Overflow: second entry, then extra key while valid
    press(4'h8, 40);
    press(4'h9, 40);
    press(4'hA, 40);
    press(4'hB, 40);
    check("ent2_x", X, 8'h89);
    check("ent2_y", Y, 8'hAB);
    s0 = nstb;
    press(4'hF, 40);
    check("ovf_strobes", nstb - s0, 1);
    check("ovf_code", key_code, 4'hF);
    check("ovf_buf", entry_buf, 16'h89AB);
    check("ovf_x", X, 8'h89);
    check("ovf_y", Y, 8'hAB);
    check("ovf_cnt", digit_cnt, 3'd4);
    check("ovf_valid", op_valid, 1'b1);

    // Ack in the same cycle as a strobe
    set_key(4'h5);
    pressed = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1);
      if (key_strobe) ok = 1'b1;
    end
    check("samecyc_seen", ok, 1'b1);
    op_ack = 1'b1;
    step(1);
    op_ack = 1'b0;
    pressed = 1'b0;
    step(30);
    check("samecyc_valid", op_valid, 1'b0);
    check("samecyc_cnt", digit_cnt, 3'd0);
    check("samecyc_buf", entry_buf, 16'h89AB);
    check("samecyc_x", X, 8'h89);

    // Bounce on key A, then stable
    do_reset();
    s0 = nstb;
    set_key(4'hA);
    for (int i = 0; i < 20; i++) begin
      pressed = ((i / 3) % 2) == 0;
      step(1);
    end
    t0 = cyc;
    pressed = 1'b1;
    step(30);
    pressed = 1'b0;
    step(30);
    check("bounce_strobes", nstb - s0, 1);
    check("bounce_after", last_stb >= t0, 1'b1);
    check("bounce_code", key_code, 4'hA);
    check("bounce_buf", entry_buf, 16'h000A);

    // Multi-key rows 0 and 2 on col1
    do_reset();
    s0 = nstb;
    prow = 4'b0101;
    pcol = 2'd1;
    pressed = 1'b1;
    wait_col(4'b1101, ok);
    check("multi_col_seen", ok, 1'b1);
    step(30);
    check("multi_frozen", KEY_C, 4'b1101);
    check("multi_strobes", nstb - s0, 0);
    pressed = 1'b0;
    step(8);
    check("multi_hold", KEY_C, 4'b1101);
    step(4);
    check("multi_next", KEY_C, 4'b1011);
    check("multi_cnt", digit_cnt, 3'd0);

    // Reset mid-debounce with three digits entered
    do_reset();
    press(4'h1, 40);
    press(4'h2, 40);
    press(4'h3, 40);
    check("pre_clr_cnt", digit_cnt, 3'd3);
    set_key(4'h4);
    pressed = 1'b1;
    for (int i = 0; i < 40 && KEY_C == 4'b1110; i++) step(1);
    wait_col(4'b1110, ok);
    check("clr_col_seen", ok, 1'b1);
    step(6);
    s0 = nstb;
    #2;
    clr = 1'b1;
    pressed = 1'b0;
    #1;
    check("clr_keyc", KEY_C, 4'b1110);
    check("clr_cnt", digit_cnt, 3'd0);
    check("clr_valid", op_valid, 1'b0);
    check("clr_x", X, 8'h00);
    check("clr_y", Y, 8'h00);
    check("clr_buf", entry_buf, 16'h0000);
    step(2);
    clr = 1'b0;
    step(40);
    check("clr_no_strobe", nstb - s0, 0);
    check("clr_cnt_after", digit_cnt, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
